// File: rtl/vga_pll_pkg.sv
// Shared definitions for the VGA PLL reset/lock controller: state encoding,
// default cycle constants and a sizing helper.
package vga_pll_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 1000000;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES         = 3;
    localparam int DEF_SYNC_STAGES         = 2;

    function automatic int max_of3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/vga_pll_reset_ctrl_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; output clears
// asynchronously with rst.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/vga_pll_reset_ctrl.sv
// Drives the VGA PLL areset, waits for a stable synchronized lock, then
// releases the video reset; re-arms on timeout or lock loss, faults when retries run out.
module vga_pll_reset_ctrl
    import vga_pll_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
    input  logic          refclk,
    input  logic          rst,
    input  logic          pll_locked,
    output logic          pll_areset,
    output logic          sys_reset,
    output logic          ready,
    output logic          fault,
    output logic          lock_loss,
    output logic [RW-1:0] retry_count,
    output state_t        dbg_state
);

    localparam int CMAX = max_of3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

    state_t          state, state_nxt;
    logic [CW-1:0]   counter;
    logic [RW-1:0]   retry_nxt;
    logic            locked_s;
    logic            attempt_failed;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // A failed attempt (timeout or lock glitch before RUN) either re-arms or gives up.
    always_comb begin
        state_nxt      = state;
        retry_nxt      = retry_count;
        attempt_failed = 1'b0;
        case (state)
            RESET_PLL: begin
                if (counter == CW'(RST_PULSE_CYCLES - 1)) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) state_nxt = STABILIZE;
                else if (counter == CW'(LOCK_TIMEOUT_CYCLES - 1)) attempt_failed = 1'b1;
            end
            STABILIZE: begin
                if (!locked_s) begin
                    attempt_failed = 1'b1;
                end else if (counter == CW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_nxt = RUN;
                    retry_nxt = '0;
                end
            end
            RUN: begin
                retry_nxt = '0;
                if (!locked_s) state_nxt = RESET_PLL;
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = RESET_PLL;
            end
        endcase
        if (attempt_failed) begin
            if (retry_count == RW'(MAX_RETRIES)) begin
                state_nxt = FAULT;
            end else begin
                state_nxt = RESET_PLL;
                retry_nxt = retry_count + RW'(1);
            end
        end
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= RESET_PLL;
            counter     <= '0;
            retry_count <= '0;
            pll_areset  <= 1'b1;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
            lock_loss   <= 1'b0;
        end else begin
            state       <= state_nxt;
            counter     <= (state_nxt != state) ? '0 : counter + CW'(1);
            retry_count <= retry_nxt;
            pll_areset  <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
            sys_reset   <= (state_nxt != RUN);
            ready       <= (state_nxt == RUN);
            fault       <= fault | (state_nxt == FAULT);
            lock_loss   <= (state == RUN) && !locked_s;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_vga_pll_reset_ctrl.sv
// Bench for vga_pll_reset_ctrl with small cycle parameters; expected event
// timings are queued when stimulus is applied and popped when events occur.
module tb_vga_pll_reset_ctrl;
    import vga_pll_pkg::*;

    localparam int RST_PULSE = 4;
    localparam int TIMEOUT   = 50;
    localparam int STABLE    = 8;
    localparam int MAXR      = 2;
    localparam int SYNC      = 2;
    localparam int RW        = 2;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          pll_areset, sys_reset, ready, fault, lock_loss;
    logic [RW-1:0] retry_count;
    state_t        dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int ready_hits = 0;
    logic [31:0] exp_q[$];

    vga_pll_reset_ctrl #(
        .RST_PULSE_CYCLES    (RST_PULSE),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT),
        .LOCK_STABLE_CYCLES  (STABLE),
        .MAX_RETRIES         (MAXR),
        .SYNC_STAGES         (SYNC)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_areset  (pll_areset),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .fault       (fault),
        .lock_loss   (lock_loss),
        .retry_count (retry_count),
        .dbg_state   (dbg_state)
    );

    always #10 refclk = ~refclk;

    always @(negedge refclk) if (ready === 1'b1) ready_hits++;

    function automatic logic sig(input int which);
        case (which)
            0: return pll_areset;
            1: return ready;
            2: return fault;
            default: return lock_loss;
        endcase
    endfunction

    // Counts rising edges until the selected output reaches val; max_cyc+1 on timeout.
    task automatic wait_until(input int which, input logic val, input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(negedge refclk);
            cyc++;
        end while (sig(which) !== val && cyc <= max_cyc);
    endtask

    function automatic logic [31:0] pop_exp();
        if (exp_q.size() != 0) return exp_q.pop_front();
        return 32'hFFFF_FFFF;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (2) @(negedge refclk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] v;
        rst = 1'b1;
        @(negedge refclk);
        v = {pll_areset, sys_reset, ready, fault, lock_loss, retry_count};
        n_tests++;
        if (v !== 7'b1100000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 1100000", v);
        end
        n_tests++;
        if (dbg_state !== RESET_PLL) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, RESET_PLL);
        end
    endtask

    task automatic test_lock_latency();
        int c;
        logic [31:0] e;
        do_reset();
        exp_q.push_back(RST_PULSE);
        wait_until(0, 1'b0, 40, c);
        e = pop_exp();
        n_tests++;
        if (c !== e) begin n_fail++; $display("FAIL first_areset_width: got %0d expected %0d", c, e); end
        repeat (10) @(negedge refclk);
        pll_locked = 1'b1;
        exp_q.push_back(SYNC + STABLE + 1);
        wait_until(1, 1'b1, 60, c);
        e = pop_exp();
        n_tests++;
        if (c !== e) begin n_fail++; $display("FAIL lock_to_ready: got %0d expected %0d", c, e); end
        n_tests++;
        if ({sys_reset, retry_count} !== 3'b000) begin
            n_fail++;
            $display("FAIL run_outputs: sys_reset=%b retry=%0d expected 0/0", sys_reset, retry_count);
        end
    endtask

    task automatic test_timeout_fault();
        logic prev;
        logic fault_seen;
        logic [31:0] e;
        do_reset();
        for (int k = 0; k <= MAXR; k++) begin
            exp_q.push_back(RST_PULSE + k * (TIMEOUT + RST_PULSE));
            exp_q.push_back(k);
        end
        exp_q.push_back((MAXR + 1) * (RST_PULSE + TIMEOUT));
        prev = pll_areset;
        fault_seen = 1'b0;
        for (int c = 1; c <= 175; c++) begin
            @(negedge refclk);
            if (prev === 1'b1 && pll_areset === 1'b0) begin
                e = pop_exp();
                n_tests++;
                if (c !== e) begin n_fail++; $display("FAIL areset_fall_cycle: got %0d expected %0d", c, e); end
                e = pop_exp();
                n_tests++;
                if (32'(retry_count) !== e) begin n_fail++; $display("FAIL retry_in_wait: got %0d expected %0d", retry_count, e); end
            end
            if (fault === 1'b1 && !fault_seen) begin
                fault_seen = 1'b1;
                e = pop_exp();
                n_tests++;
                if (c !== e) begin n_fail++; $display("FAIL fault_cycle: got %0d expected %0d", c, e); end
            end
            if (fault_seen) begin
                n_tests++;
                if ({pll_areset, sys_reset, ready} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL fault_hold: areset/sys_reset/ready=%b expected 110", {pll_areset, sys_reset, ready});
                end
            end
            prev = pll_areset;
        end
        n_tests++;
        if (exp_q.size() != 0 || retry_count !== RW'(MAXR)) begin
            n_fail++;
            $display("FAIL fault_events: %0d missing events, retry=%0d expected 0 and %0d", exp_q.size(), retry_count, MAXR);
            exp_q.delete();
        end
    endtask

    task automatic test_stabilize_glitch();
        int c;
        logic [31:0] e;
        do_reset();
        ready_hits = 0;
        wait_until(0, 1'b0, 40, c);
        pll_locked = 1'b1;
        repeat (6) @(negedge refclk);
        pll_locked = 1'b0;
        @(negedge refclk);
        pll_locked = 1'b1;
        exp_q.push_back(2);
        wait_until(0, 1'b1, 20, c);
        e = pop_exp();
        n_tests++;
        if (c !== e) begin n_fail++; $display("FAIL glitch_rearm_delay: got %0d expected %0d", c, e); end
        pll_locked = 1'b0;
        exp_q.push_back(RST_PULSE);
        wait_until(0, 1'b0, 20, c);
        e = pop_exp();
        n_tests++;
        if (c !== e) begin n_fail++; $display("FAIL glitch_areset_width: got %0d expected %0d", c, e); end
        n_tests++;
        if (retry_count !== 2'd1 || ready_hits != 0) begin
            n_fail++;
            $display("FAIL glitch_retry: retry=%0d ready_hits=%0d expected 1/0", retry_count, ready_hits);
        end
        repeat (3) @(negedge refclk);
        pll_locked = 1'b1;
        exp_q.push_back(SYNC + STABLE + 1);
        wait_until(1, 1'b1, 60, c);
        e = pop_exp();
        n_tests++;
        if (c !== e || retry_count !== 2'd0) begin
            n_fail++;
            $display("FAIL glitch_relock: latency=%0d retry=%0d expected %0d/0", c, retry_count, e);
        end
    endtask

    task automatic test_lock_loss();
        int c;
        logic [31:0] e;
        n_tests++;
        if (lock_loss !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL run_before_loss: lock_loss=%b ready=%b expected 0/1", lock_loss, ready);
        end
        pll_locked = 1'b0;
        exp_q.push_back(SYNC + 1);
        wait_until(3, 1'b1, 20, c);
        e = pop_exp();
        n_tests++;
        if (c !== e) begin n_fail++; $display("FAIL lock_loss_delay: got %0d expected %0d", c, e); end
        n_tests++;
        if ({ready, sys_reset, pll_areset} !== 3'b011) begin
            n_fail++;
            $display("FAIL loss_outputs: ready/sys_reset/areset=%b expected 011", {ready, sys_reset, pll_areset});
        end
        @(negedge refclk);
        n_tests++;
        if (lock_loss !== 1'b0) begin n_fail++; $display("FAIL lock_loss_pulse: got %b expected 0", lock_loss); end
        exp_q.push_back(RST_PULSE - 1);
        wait_until(0, 1'b0, 20, c);
        e = pop_exp();
        n_tests++;
        if (c !== e) begin n_fail++; $display("FAIL loss_areset_rest: got %0d expected %0d", c, e); end
        repeat (2) @(negedge refclk);
        pll_locked = 1'b1;
        exp_q.push_back(SYNC + STABLE + 1);
        wait_until(1, 1'b1, 60, c);
        e = pop_exp();
        n_tests++;
        if (c !== e) begin n_fail++; $display("FAIL loss_relock: got %0d expected %0d", c, e); end
    endtask

    task automatic test_async_reset();
        int c;
        logic [6:0] v;
        logic [31:0] e;
        do_reset();
        wait_until(0, 1'b0, 40, c);
        pll_locked = 1'b1;
        repeat (5) @(negedge refclk);
        n_tests++;
        if (dbg_state !== STABILIZE) begin n_fail++; $display("FAIL mid_stabilize: state=%0d expected %0d", dbg_state, STABILIZE); end
        #3 rst = 1'b1;
        #1 v = {pll_areset, sys_reset, ready, fault, lock_loss, retry_count};
        n_tests++;
        if (v !== 7'b1100000 || dbg_state !== RESET_PLL) begin
            n_fail++;
            $display("FAIL async_rst_stabilize: outputs=%b state=%0d expected 1100000/0", v, dbg_state);
        end
        @(negedge refclk);
        pll_locked = 1'b0;
        rst = 1'b0;
        wait_until(2, 1'b1, 200, c);
        #3 rst = 1'b1;
        #1 v = {pll_areset, sys_reset, ready, fault, lock_loss, retry_count};
        n_tests++;
        if (v !== 7'b1100000 || dbg_state !== RESET_PLL) begin
            n_fail++;
            $display("FAIL async_rst_fault: outputs=%b state=%0d expected 1100000/0", v, dbg_state);
        end
        @(negedge refclk);
        rst = 1'b0;
        exp_q.push_back(RST_PULSE);
        wait_until(0, 1'b0, 40, c);
        e = pop_exp();
        n_tests++;
        if (c !== e || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_after_rst: width=%0d fault=%b expected %0d/0", c, fault, e);
        end
    endtask

    task automatic test_timeout_edge_lock();
        int c;
        logic [31:0] e;
        do_reset();
        wait_until(0, 1'b0, 40, c);
        repeat (TIMEOUT - 3) @(negedge refclk);
        pll_locked = 1'b1;
        repeat (3) @(negedge refclk);
        n_tests++;
        if (dbg_state !== STABILIZE || retry_count !== 2'd0 || pll_areset !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_edge_lock: state=%0d retry=%0d areset=%b expected %0d/0/0",
                     dbg_state, retry_count, pll_areset, STABILIZE);
        end
        exp_q.push_back(STABLE);
        wait_until(1, 1'b1, 40, c);
        e = pop_exp();
        n_tests++;
        if (c !== e) begin n_fail++; $display("FAIL timeout_edge_ready: got %0d expected %0d", c, e); end
    endtask

    initial begin
        test_reset();
        test_lock_latency();
        test_timeout_fault();
        test_stabilize_glitch();
        test_lock_loss();
        test_async_reset();
        test_timeout_edge_lock();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
